// File: rtl/alu_seq_if.sv
// Handshake/operand bundle between the execute-stage operand muxes and alu_seq.
// The master side issues operations; the slave side (the ALU) returns results and flags.
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             is_greater;
    logic             overflow;
    logic             illegal_op;
    logic             busy;

    modport master (
        output in_valid, a, b, alu_op, out_ready,
        input  in_ready, out_valid, result, zero, is_greater, overflow, illegal_op, busy
    );

    modport slave (
        input  in_valid, a, b, alu_op, out_ready,
        output in_ready, out_valid, result, zero, is_greater, overflow, illegal_op, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops, iterative MUL/DIVU/REMU.
// The iterative ops exist only when ALU_MULDIV_EN is defined; otherwise they decode as illegal.
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, BUSY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

    state_t           state;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, gt_q, ovf_q, ill_q;

    // Single-cycle datapath, evaluated on the live operands at accept
    logic [WIDTH-1:0] sum, diff, sc_res;
    logic             sc_ovf, sc_ill, is_md;

    always_comb begin
        sum    = bus.a + bus.b;
        diff   = bus.a - bus.b;
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        is_md  = 1'b0;
        case (bus.alu_op)
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_NOR:  sc_res = ~(bus.a | bus.b);
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLL:  sc_res = bus.a << bus.b[SHAMT_W-1:0];
            OP_SRL:  sc_res = bus.a >> bus.b[SHAMT_W-1:0];
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_DIVU, OP_REMU: is_md = 1'b1;
`endif
            default: sc_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // acc: product accumulator / partial remainder; x: multiplicand / dividend->quotient;
    // y: multiplier (consumed LSB first) / divisor.
    logic [WIDTH-1:0]   acc_q, x_q, y_q, acc_n, x_n, y_n, md_res, rem_sub;
    logic [3:0]         op_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH:0]     rem_sh;
    logic               ge;

    always_comb begin
        rem_sh  = {acc_q, x_q[WIDTH-1]};
        ge      = rem_sh >= {1'b0, y_q};
        rem_sub = rem_sh[WIDTH-1:0] - y_q;
        if (op_q == OP_MUL) begin
            acc_n = acc_q + (y_q[0] ? x_q : '0);
            x_n   = x_q << 1;
            y_n   = y_q >> 1;
        end else begin
            // b==0 makes every step "fit": quotient all ones, remainder ends as a
            acc_n = ge ? rem_sub : rem_sh[WIDTH-1:0];
            x_n   = {x_q[WIDTH-2:0], ge};
            y_n   = y_q;
        end
        md_res = (op_q == OP_DIVU) ? x_n : acc_n;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            gt_q        <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
`ifdef ALU_MULDIV_EN
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            op_q  <= '0;
            cnt_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    gt_q       <= bus.a > bus.b;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
`ifdef ALU_MULDIV_EN
                    if (is_md) begin
                        acc_q <= '0;
                        x_q   <= bus.a;
                        y_q   <= bus.b;
                        op_q  <= bus.alu_op;
                        cnt_q <= SHAMT_W'(WIDTH - 1);
                        ovf_q <= 1'b0;
                        ill_q <= 1'b0;
                        state <= BUSY;
                    end else
`endif
                    begin
                        result_q    <= sc_res;
                        zero_q      <= (sc_res == '0);
                        ovf_q       <= sc_ovf;
                        ill_q       <= sc_ill;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
`ifdef ALU_MULDIV_EN
                BUSY: begin
                    acc_q <= acc_n;
                    x_q   <= x_n;
                    y_q   <= y_n;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_q    <= md_res;
                        zero_q      <= (md_res == '0);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
`endif
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.is_greater = gt_q;
    assign bus.overflow   = ovf_q;
    assign bus.illegal_op = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for single ops plus hand sequences for
// backpressure, held in_valid and mid-operation reset. Follows ALU_MULDIV_EN if defined.
module tb_alu_seq;
    localparam int W = 64;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a, b, res;
        logic         z, gt, ovf, ill;
        int           lat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [3:0] op, input logic [W-1:0] a, b, res,
                           input logic z, gt, ovf, ill, input int lat);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.res = res;
        v.z = z; v.gt = gt; v.ovf = ovf; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Present one op, return cycles from accept edge until out_valid (accept edge counts as 1)
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, output int lat);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_issue", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.alu_op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_flags"}, {bus.zero, bus.is_greater, bus.overflow, bus.illegal_op, bus.busy}, 0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.alu_op = '0;

        add_vec("add_5_7",   4'b0010, 5, 7, 12, 0, 0, 0, 0, 1);
        add_vec("add_ovf",   4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 0, 1, 1, 0, 1);
        add_vec("add_wrap",  4'b0010, ONES, 1, 0, 1, 1, 0, 0, 1);
        add_vec("sub_3_3",   4'b0110, 3, 3, 0, 1, 0, 0, 0, 1);
        add_vec("sub_neg",   4'b0110, 5, 7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 1);
        add_vec("sub_ovf",   4'b0110, 64'h8000_0000_0000_0000, 1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1, 0, 1);
        add_vec("sll_43",    4'b0111, 1, 64'h43, 8, 0, 0, 0, 0, 1);
        add_vec("srl_4",     4'b0100, 64'h80, 4, 8, 0, 1, 0, 0, 1);
        add_vec("srl_upper", 4'b0100, 64'h80, 64'h104, 8, 0, 0, 0, 0, 1);
        add_vec("and",       4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 0, 0, 0, 0, 1);
        add_vec("or",        4'b0001, 64'hF0, 64'h0F, 64'hFF, 0, 1, 0, 0, 1);
        add_vec("nor",       4'b1100, 0, 0, ONES, 0, 0, 0, 0, 1);
        add_vec("illegal_f", 4'b1111, 5, 3, 0, 1, 1, 0, 1, 1);
`ifdef ALU_MULDIV_EN
        add_vec("mul",       4'b1000, 64'h1_0000_0001, 3, 64'h3_0000_0003, 0, 1, 0, 0, 65);
        add_vec("mul_wrap",  4'b1000, ONES, 2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, 65);
        add_vec("divu",      4'b1001, 100, 7, 14, 0, 1, 0, 0, 65);
        add_vec("remu",      4'b1010, 100, 7, 2, 0, 1, 0, 0, 65);
        add_vec("divu_by0",  4'b1001, 9, 0, ONES, 0, 1, 0, 0, 65);
        add_vec("remu_by0",  4'b1010, 9, 0, 9, 0, 1, 0, 0, 65);
`else
        add_vec("mul_ill",   4'b1000, 3, 3, 0, 1, 0, 0, 1, 1);
        add_vec("divu_ill",  4'b1001, 100, 7, 0, 1, 1, 0, 1, 1);
        add_vec("remu_ill",  4'b1010, 100, 7, 0, 1, 1, 0, 1, 1);
`endif

        #12;
        check_reset_outputs("reset");
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("post_reset");

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_result"}, bus.result, vecs[i].res);
            check({vecs[i].name, "_zero"}, bus.zero, vecs[i].z);
            check({vecs[i].name, "_gt"}, bus.is_greater, vecs[i].gt);
            check({vecs[i].name, "_ovf"}, bus.overflow, vecs[i].ovf);
            check({vecs[i].name, "_ill"}, bus.illegal_op, vecs[i].ill);
            consume();
            check({vecs[i].name, "_released"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
        end

        // Backpressure: result and flags must hold while out_ready stays low
        issue(4'b0010, 5, 7, lat);
        held = bus.result;
        check("hold_initial", held, 12);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_result", bus.result, 12);
            check("hold_ctl", {bus.out_valid, bus.in_ready, bus.busy}, 3'b101);
        end
        consume();

        // in_valid held high while not IDLE must not start a new op
        @(negedge clk);
`ifdef ALU_MULDIV_EN
        bus.in_valid = 1'b1; bus.alu_op = 4'b1000; bus.a = 64'h1_0000_0001; bus.b = 3;
        @(posedge clk); #1;
        bus.alu_op = 4'b0010; bus.a = 1; bus.b = 1;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (lat == 10) check("busy_ctl", {bus.in_ready, bus.busy}, 2'b01);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        check("held_mul_lat", lat, 65);
        check("held_mul_result", bus.result, 64'h3_0000_0003);
`else
        bus.in_valid = 1'b1; bus.alu_op = 4'b0010; bus.a = 5; bus.b = 7;
        @(posedge clk); #1;
        bus.a = 1; bus.b = 1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("held_add_result", bus.result, 12);
        check("held_add_ctl", {bus.out_valid, bus.in_ready}, 2'b10);
`endif
        consume();

        // Reset mid-operation: outputs clear at once, no stale result afterwards
        @(negedge clk);
`ifdef ALU_MULDIV_EN
        bus.in_valid = 1'b1; bus.alu_op = 4'b1000; bus.a = 64'h1234; bus.b = 64'h5678;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        check("pre_reset_busy", bus.busy, 1);
`else
        bus.in_valid = 1'b1; bus.alu_op = 4'b0010; bus.a = 64'h1234; bus.b = 64'h5678;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("pre_reset_valid", bus.out_valid, 1);
`endif
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk); reset_n = 1'b1;
        repeat (70) @(posedge clk);
        #1;
        check_reset_outputs("after_release");

        issue(4'b0010, 1, 1, lat);
        check("post_reset_add_lat", lat, 1);
        check("post_reset_add_result", bus.result, 2);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
